// File: rtl/pw_lock_ctrl_if.sv
// Signal bundle between the attempt-limiting controller, the raw switches and the password FSM.
interface pw_lock_ctrl_if #(
   parameter int CNT_W = 28
) ();
   logic [9:0]       key_in;
   logic             fsm_correct;
   logic             fsm_error;
   logic [9:0]       fsm_comb;
   logic             fsm_rst;
   logic             locked;
   logic             unlocked;
   logic [2:0]       fail_cnt;
   logic [CNT_W-1:0] remain;

   modport slave (
      input  key_in, fsm_correct, fsm_error,
      output fsm_comb, fsm_rst, locked, unlocked, fail_cnt, remain
   );

   modport master (
      output key_in, fsm_correct, fsm_error,
      input  fsm_comb, fsm_rst, locked, unlocked, fail_cnt, remain
   );
endinterface

// File: rtl/pw_lock_ctrl.sv
// Attempt-limiting and relock controller sitting in front of the password FSM.
//
// state    | meaning
// WAIT_REL | FSM held in reset until every switch is released
// ARMED    | keys forwarded to FSM, error/correct rises counted
// LOCKOUT  | too many failures; FSM held in reset for LOCK_CYCLES
// OPEN     | correct entry; FSM frozen in its correct state for OPEN_CYCLES
module pw_lock_ctrl #(
   parameter int MAX_FAIL    = 3,
   parameter int LOCK_CYCLES = 250_000_000,
   parameter int OPEN_CYCLES = 250_000_000,
   parameter int CNT_W       = 28
) (
   input  logic           clk,
   input  logic           rst,
   pw_lock_ctrl_if.slave  bus
);

   typedef enum logic [1:0] {
      WAIT_REL = 2'd0,
      ARMED    = 2'd1,
      LOCKOUT  = 2'd2,
      OPEN     = 2'd3
   } state_t;

   localparam logic [2:0]       FAIL_LIM  = 3'(MAX_FAIL);
   localparam logic [CNT_W-1:0] LOCK_LOAD = CNT_W'(LOCK_CYCLES - 1);
   localparam logic [CNT_W-1:0] OPEN_LOAD = CNT_W'(OPEN_CYCLES - 1);

   state_t           state_q;
   logic [CNT_W-1:0] timer_q;
   logic [2:0]       fail_q;
   logic [9:0]       comb_q;
   logic             frst_q;
   logic             locked_q;
   logic             unlocked_q;
   logic             err_q;
   logic             cor_q;

   logic err_rise;
   logic cor_rise;

   assign err_rise = bus.fsm_error & ~err_q;
   assign cor_rise = bus.fsm_correct & ~cor_q;

   // The timer is zero outside the timed states, so it can drive remain directly.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= WAIT_REL;
         timer_q    <= '0;
         fail_q     <= '0;
         comb_q     <= '0;
         frst_q     <= 1'b0;
         locked_q   <= 1'b0;
         unlocked_q <= 1'b0;
         err_q      <= 1'b0;
         cor_q      <= 1'b0;
      end else begin
         err_q <= bus.fsm_error;
         cor_q <= bus.fsm_correct;
         case (state_q)
            WAIT_REL: begin
               comb_q <= '0;
               frst_q <= 1'b0;
               if (bus.key_in == 10'd0) begin
                  state_q <= ARMED;
                  frst_q  <= 1'b1;
               end
            end
            ARMED: begin
               comb_q <= bus.key_in;
               if (cor_rise) begin
                  state_q    <= OPEN;
                  fail_q     <= '0;
                  timer_q    <= OPEN_LOAD;
                  unlocked_q <= 1'b1;
                  comb_q     <= '0;
               end else if (err_rise && (fail_q + 3'd1 == FAIL_LIM)) begin
                  state_q  <= LOCKOUT;
                  fail_q   <= '0;
                  timer_q  <= LOCK_LOAD;
                  locked_q <= 1'b1;
                  frst_q   <= 1'b0;
                  comb_q   <= '0;
               end else if (err_rise) begin
                  fail_q <= fail_q + 3'd1;
               end
            end
            LOCKOUT: begin
               comb_q <= '0;
               frst_q <= 1'b0;
               if (timer_q == '0) begin
                  state_q  <= WAIT_REL;
                  locked_q <= 1'b0;
               end else begin
                  timer_q <= timer_q - 1'b1;
               end
            end
            OPEN: begin
               comb_q <= '0;
               if (timer_q == '0) begin
                  state_q    <= WAIT_REL;
                  unlocked_q <= 1'b0;
                  frst_q     <= 1'b0;
               end else begin
                  timer_q <= timer_q - 1'b1;
               end
            end
            default: state_q <= WAIT_REL;
         endcase
      end
   end

   assign bus.fsm_comb = comb_q;
   assign bus.fsm_rst  = frst_q;
   assign bus.locked   = locked_q;
   assign bus.unlocked = unlocked_q;
   assign bus.fail_cnt = fail_q;
   assign bus.remain   = timer_q;

endmodule

// File: tb/tb_pw_lock_ctrl.sv
// Directed bench for pw_lock_ctrl with MAX_FAIL=3, LOCK_CYCLES=8, OPEN_CYCLES=5.
module tb_pw_lock_ctrl;

   localparam int CNT_W = 4;

   logic clk;
   logic rst;
   int   n_chk;
   int   n_err;

   pw_lock_ctrl_if #(.CNT_W(CNT_W)) bus ();

   pw_lock_ctrl #(
      .MAX_FAIL   (3),
      .LOCK_CYCLES(8),
      .OPEN_CYCLES(5),
      .CNT_W      (CNT_W)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reset, then let the first edge with released keys arm the FSM.
   task automatic restart();
      rst = 1'b0;
      bus.key_in = '0;
      bus.fsm_error = 1'b0;
      bus.fsm_correct = 1'b0;
      tick();
      rst = 1'b1;
      tick();
   endtask

   task automatic err_pulse();
      bus.fsm_error = 1'b1;
      tick();
      bus.fsm_error = 1'b0;
      tick();
   endtask

   initial begin
      n_chk = 0;
      n_err = 0;
      rst = 1'b0;
      bus.key_in = '0;
      bus.fsm_error = 1'b0;
      bus.fsm_correct = 1'b0;

      // Reset values
      tick();
      chk("rst_comb", 32'(bus.fsm_comb), 32'h0);
      chk("rst_frst", 32'(bus.fsm_rst), 32'h0);
      chk("rst_locked", 32'(bus.locked), 32'h0);
      chk("rst_unlocked", 32'(bus.unlocked), 32'h0);
      chk("rst_fail", 32'(bus.fail_cnt), 32'h0);
      chk("rst_remain", 32'(bus.remain), 32'h0);

      // 1: release, arm, forward a key
      rst = 1'b1;
      #1;
      chk("t1_wait_frst", 32'(bus.fsm_rst), 32'h0);
      tick();
      chk("t1_armed_frst", 32'(bus.fsm_rst), 32'h1);
      chk("t1_armed_fail", 32'(bus.fail_cnt), 32'h0);
      bus.key_in = 10'h200;
      #1;
      chk("t1_comb_lat", 32'(bus.fsm_comb), 32'h0);
      tick();
      chk("t1_comb", 32'(bus.fsm_comb), 32'h200);
      bus.key_in = 10'h000;
      tick();
      chk("t1_comb_rel", 32'(bus.fsm_comb), 32'h0);

      // 2: held error counts once
      bus.fsm_error = 1'b1;
      tick();
      chk("t2_fail_rise", 32'(bus.fail_cnt), 32'h1);
      for (int i = 0; i < 3; i++) tick();
      bus.fsm_error = 1'b0;
      tick();
      chk("t2_fail_held", 32'(bus.fail_cnt), 32'h1);
      chk("t2_locked", 32'(bus.locked), 32'h0);
      err_pulse();
      chk("t2_fail_two", 32'(bus.fail_cnt), 32'h2);

      // 3: three separate failures -> lockout of 8 cycles
      restart();
      err_pulse();
      err_pulse();
      chk("t3_fail2", 32'(bus.fail_cnt), 32'h2);
      bus.fsm_error = 1'b1;
      tick();
      bus.fsm_error = 1'b0;
      bus.key_in = 10'h3FF;
      for (int i = 0; i < 8; i++) begin
         chk("t3_locked", 32'(bus.locked), 32'h1);
         chk("t3_remain", 32'(bus.remain), 32'(7 - i));
         chk("t3_frst", 32'(bus.fsm_rst), 32'h0);
         chk("t3_comb", 32'(bus.fsm_comb), 32'h0);
         chk("t3_fail", 32'(bus.fail_cnt), 32'h0);
         tick();
      end
      chk("t3_locked_end", 32'(bus.locked), 32'h0);
      chk("t3_remain_end", 32'(bus.remain), 32'h0);
      tick();
      chk("t3_wait_frst", 32'(bus.fsm_rst), 32'h0);
      bus.key_in = 10'h000;
      tick();
      chk("t3_rearm", 32'(bus.fsm_rst), 32'h1);

      // 4: correct after two failures -> open for 5 cycles, then wait for release
      err_pulse();
      err_pulse();
      chk("t4_fail2", 32'(bus.fail_cnt), 32'h2);
      bus.fsm_correct = 1'b1;
      tick();
      bus.key_in = 10'h001;
      for (int i = 0; i < 5; i++) begin
         chk("t4_unlocked", 32'(bus.unlocked), 32'h1);
         chk("t4_remain", 32'(bus.remain), 32'(4 - i));
         chk("t4_fail", 32'(bus.fail_cnt), 32'h0);
         chk("t4_frst", 32'(bus.fsm_rst), 32'h1);
         chk("t4_comb", 32'(bus.fsm_comb), 32'h0);
         tick();
      end
      bus.fsm_correct = 1'b0;
      chk("t4_unlocked_end", 32'(bus.unlocked), 32'h0);
      chk("t4_frst_end", 32'(bus.fsm_rst), 32'h0);
      for (int i = 0; i < 10; i++) tick();
      chk("t4_wait_hold", 32'(bus.fsm_rst), 32'h0);
      chk("t4_wait_comb", 32'(bus.fsm_comb), 32'h0);
      bus.key_in = 10'h000;
      tick();
      chk("t4_rearm", 32'(bus.fsm_rst), 32'h1);

      // 5: asynchronous reset mid-lockout
      restart();
      err_pulse();
      err_pulse();
      bus.fsm_error = 1'b1;
      tick();
      bus.fsm_error = 1'b0;
      tick();
      tick();
      tick();
      chk("t5_remain4", 32'(bus.remain), 32'h4);
      #2;
      rst = 1'b0;
      #1;
      chk("t5_locked", 32'(bus.locked), 32'h0);
      chk("t5_remain", 32'(bus.remain), 32'h0);
      chk("t5_frst", 32'(bus.fsm_rst), 32'h0);
      chk("t5_fail", 32'(bus.fail_cnt), 32'h0);
      tick();
      rst = 1'b1;
      #1;
      chk("t5_wait", 32'(bus.fsm_rst), 32'h0);
      tick();
      chk("t5_rearm", 32'(bus.fsm_rst), 32'h1);

      // 6: simultaneous correct and error at fail_cnt=2 -> open wins
      err_pulse();
      err_pulse();
      chk("t6_fail2", 32'(bus.fail_cnt), 32'h2);
      bus.fsm_error = 1'b1;
      bus.fsm_correct = 1'b1;
      tick();
      bus.fsm_error = 1'b0;
      bus.fsm_correct = 1'b0;
      chk("t6_unlocked", 32'(bus.unlocked), 32'h1);
      chk("t6_locked", 32'(bus.locked), 32'h0);
      chk("t6_fail", 32'(bus.fail_cnt), 32'h0);
      chk("t6_remain", 32'(bus.remain), 32'h4);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

// File: doc/pw_lock_ctrl.md
# pw_lock_ctrl

Attempt-limiting and relock controller placed between the ten raw switches and the password FSM (`pwFSM`). It forwards key input to the FSM and counts error events. After `MAX_FAIL` consecutive failures it locks the FSM out for a fixed time. After a correct entry it holds the open state for a fixed time, then rearms the FSM once all switches are released.

## Interface
- `MAX_FAIL`, default 3: failed attempts that trigger lockout; range 1..7.
- `LOCK_CYCLES`, default 250_000_000: lockout duration in clk cycles (5 s at 50 MHz); must be ≥1.
- `OPEN_CYCLES`, default 250_000_000: open (unlocked) duration in clk cycles; must be ≥1.
- `CNT_W`, default 28: timer width; must hold max(LOCK_CYCLES, OPEN_CYCLES)-1.
- `clk`  in  1  system clock; the only clock.
- `rst`  in  1  reset, asynchronous, active-low.
- `key_in`  in  10  raw switch levels.
- `fsm_correct`  in  1  `correct` output of the password FSM.
- `fsm_error`  in  1  `error` output of the password FSM.
- `fsm_comb`  out  10  registered key vector driven to the FSM `comb_in`.
- `fsm_rst`  out  1  registered active-low reset driven to the FSM `rst`.
- `locked`  out  1  high while in LOCKOUT.
- `unlocked`  out  1  high while in OPEN.
- `fail_cnt`  out  3  consecutive failures since the last clear.
- `remain`  out  CNT_W  cycles left in the current timed state; 0 otherwise.

## Operation
- States: WAIT_REL, ARMED, LOCKOUT, OPEN. The reset state is WAIT_REL.
- Edge detection:
  - `err_d` and `cor_d` register `fsm_error` and `fsm_correct`; both reset to 0.
  - `err_rise = fsm_error & ~err_d`.
  - `cor_rise = fsm_correct & ~cor_d`.
  - A level held high counts once.
- WAIT_REL:
  - `fsm_rst`=0 and `fsm_comb`=0.
  - Goes to ARMED on the first clock edge with `key_in`==0.
- ARMED:
  - `fsm_rst`=1 and `fsm_comb`<=`key_in` every cycle.
  - `cor_rise`: go to OPEN, set `fail_cnt`=0, load timer with OPEN_CYCLES-1.
  - Else `err_rise` with `fail_cnt`+1==MAX_FAIL: go to LOCKOUT, set `fail_cnt`=0, load timer with LOCK_CYCLES-1.
  - Else `err_rise`: `fail_cnt`+1 and stay in ARMED. The FSM itself returns to IDLE on the next key press.
  - `cor_rise` and `err_rise` in the same cycle: correct wins and no failure is counted.
- LOCKOUT:
  - `fsm_rst`=0 and `fsm_comb`=0; `key_in` is ignored.
  - Timer decrements each cycle. When it is 0, go to WAIT_REL.
- OPEN:
  - `fsm_rst`=1 and `fsm_comb`=0, so the FSM holds its correct state and display.
  - Timer decrements each cycle. When it is 0, go to WAIT_REL.
- `remain` equals the timer in LOCKOUT and OPEN, and is 0 in the other states.
- Timer arithmetic is unsigned and never wraps; it is only loaded on entry to a timed state.
- `fail_cnt` saturates at MAX_FAIL-1 in ARMED, because reaching MAX_FAIL enters LOCKOUT and clears it.

## Timing
- All outputs are registered.
- Reset values: `fsm_comb`=0, `fsm_rst`=0, `locked`=0, `unlocked`=0, `fail_cnt`=0, `remain`=0, internal timer=0.
- Reset asserted mid-operation: every output and the state return to reset values immediately and asynchronously. `fsm_rst` asserting also resets the FSM.
- `fsm_comb` follows `key_in` with 1-cycle latency in ARMED.
- `err_rise` or `cor_rise` sampled at edge N:
  - New state and `fail_cnt` are visible after edge N.
  - `locked`/`unlocked`/`fsm_rst` change after the same edge N.
- LOCKOUT and OPEN each last exactly LOCK_CYCLES and OPEN_CYCLES cycles respectively:
  - `remain` counts LOCK_CYCLES-1 (or OPEN_CYCLES-1) down to 0.
  - WAIT_REL follows the cycle in which `remain`==0.
- WAIT_REL lasts at least 1 cycle. `fsm_rst` is therefore low for at least 1 cycle on every rearm.
- Holding switches keeps the block in WAIT_REL indefinitely, with no timeout.
- Rearm: the edge that sees `key_in`==0 in WAIT_REL sets `fsm_rst`=1. The first key is forwarded 1 cycle after it is applied.

## Test plan
All scenarios use MAX_FAIL=3, LOCK_CYCLES=8, OPEN_CYCLES=5.
1. Reset release with `key_in`=0 → WAIT_REL for 1 cycle, then ARMED with `fsm_rst`=1 and `fail_cnt`=0. Next, `key_in`=10'h200 → `fsm_comb`=10'h200 one cycle later.
2. `fsm_error` held high for 4 cycles in ARMED → `fail_cnt`=1, not 4. `locked` stays 0.
3. Three separate `fsm_error` pulses → after the third rise, `locked`=1 for exactly 8 cycles with `remain` 7..0. During lockout `fsm_rst`=0 and `fsm_comb`=0 even with `key_in`=10'h3FF; `fail_cnt`=0.
4. `fail_cnt`=2, then `fsm_correct` rises → `unlocked`=1 for 5 cycles and `fail_cnt`=0. Then WAIT_REL: `key_in`=10'h001 held for 10 cycles → WAIT_REL persists; release → ARMED next edge.
5. `rst` pulled low mid-LOCKOUT at `remain`=4 → immediately `locked`=0, `remain`=0, `fsm_rst`=0, `fail_cnt`=0. After release, normal WAIT_REL behaviour.
6. `fail_cnt`=2 and `fsm_correct`/`fsm_error` rise in the same cycle → OPEN, not LOCKOUT; `fail_cnt`=0.
